// File: rtl/pip_ctrl_pkg.sv
// Shared core definitions for the pipeline controller: hold codes, jump
// levels and the bus widths used by pc and the pipeline registers.
package pip_ctrl_pkg;

   localparam int holdpip_bus   = 2;
   localparam int inst_addr_bus = 32;

   localparam logic jump_enable  = 1'b1;
   localparam logic jump_disable = 1'b0;

   typedef enum logic [holdpip_bus-1:0] {
      hold_no    = 2'b00,
      hold_wait  = 2'b01,
      hold_flush = 2'b10
   } hold_e;

endpackage

// File: rtl/pip_ctrl_if.sv
// Request/response bundle between the pipeline controller and the units that
// stall or redirect it (execute, CLINT, bus, JTAG) plus its pc/pipeline outputs.
interface pip_ctrl_if #(
   parameter int ADDR_W = 32
);
   import pip_ctrl_pkg::*;

   logic                   ex_jump_flag_i;
   logic [ADDR_W-1:0]      ex_jump_addr_i;
   logic                   ex_hold_i;
   logic                   clint_jump_flag_i;
   logic [ADDR_W-1:0]      clint_jump_addr_i;
   logic                   clint_hold_i;
   logic                   bus_hold_i;
   logic                   jtag_halt_i;
   logic                   jtag_reset_i;
   logic [holdpip_bus-1:0] hold_flag_o;
   logic                   jump_flag_o;
   logic [ADDR_W-1:0]      jump_addr_o;
   logic                   halted_o;
   logic                   bus_timeout_o;

   // The controller side: consumes requests, produces hold/jump outputs.
   modport slave (
      input  ex_jump_flag_i, ex_jump_addr_i, ex_hold_i,
      input  clint_jump_flag_i, clint_jump_addr_i, clint_hold_i,
      input  bus_hold_i, jtag_halt_i, jtag_reset_i,
      output hold_flag_o, jump_flag_o, jump_addr_o, halted_o, bus_timeout_o
   );

   // The requesting side: raises stalls/redirects, observes the controller.
   modport master (
      output ex_jump_flag_i, ex_jump_addr_i, ex_hold_i,
      output clint_jump_flag_i, clint_jump_addr_i, clint_hold_i,
      output bus_hold_i, jtag_halt_i, jtag_reset_i,
      input  hold_flag_o, jump_flag_o, jump_addr_o, halted_o, bus_timeout_o
   );

endinterface

// File: rtl/pip_ctrl_wdt.sv
// Bus-stall watchdog: counts consecutive stalled cycles and pulses once when
// the stall reaches BUS_TIMEOUT, then stays quiet until the bus frees up.
module pip_ctrl_wdt #(
   parameter int BUS_TIMEOUT = 255
) (
   input  logic clk,
   input  logic rst,
   input  logic bus_hold_i,
   output logic bus_timeout_o
);

   localparam logic [15:0] LIMIT = 16'(BUS_TIMEOUT);

   logic [15:0] cnt_q, cnt_d;
   logic        timeout_q, timeout_d;

   // Count while stalled, saturate at the limit, fire only on the step that reaches it.
   always_comb begin
      cnt_d     = cnt_q;
      timeout_d = 1'b0;
      if (!bus_hold_i) begin
         cnt_d = '0;
      end else if (cnt_q != LIMIT) begin
         cnt_d     = cnt_q + 16'd1;
         timeout_d = (cnt_d == LIMIT);
      end
   end

   // Counter and pulse registers.
   always_ff @(posedge clk or posedge rst) begin
      if (rst) begin
         cnt_q     <= '0;
         timeout_q <= 1'b0;
      end else begin
         cnt_q     <= cnt_d;
         timeout_q <= timeout_d;
      end
   end

   assign bus_timeout_o = timeout_q;

endmodule

// File: rtl/pip_ctrl.sv
// Central pipeline controller: arbitrates redirects and stalls from execute,
// CLINT, bus and JTAG into one registered hold code and jump pulse, sequences
// multi-cycle flushes and defers redirects that land during a bus stall.
module pip_ctrl
   import pip_ctrl_pkg::*;
#(
   parameter int                ADDR_W       = inst_addr_bus,
   parameter int                FLUSH_CYCLES = 1,
   parameter logic [ADDR_W-1:0] RESET_ADDR   = '0,
   parameter int                BUS_TIMEOUT  = 255
) (
   input logic       clk,
   input logic       rst,
   pip_ctrl_if.slave pif
);

   typedef enum logic [1:0] {
      st_run   = 2'd0,
      st_flush = 2'd1,
      st_pend  = 2'd2,
      st_halt  = 2'd3
   } state_e;

   // Flush cycles that follow the redirect cycle itself.
   localparam logic [2:0] FLUSH_EXTRA = 3'(FLUSH_CYCLES - 1);

   state_e            state_q, state_d;
   hold_e             hold_q, hold_d;
   logic              jump_q, jump_d;
   logic [ADDR_W-1:0] addr_q, addr_d;
   logic              halted_q, halted_d;
   logic              pend_valid_q, pend_valid_d;
   logic              pend_clint_q, pend_clint_d;
   logic [ADDR_W-1:0] pend_addr_q, pend_addr_d;
   logic [2:0]        flush_cnt_q, flush_cnt_d;
   logic              redirect;
   logic [ADDR_W-1:0] redirect_addr;

   // Next-state and next-output arbitration; any redirect is applied uniformly at the end.
   always_comb begin
      state_d       = state_q;
      hold_d        = hold_no;
      jump_d        = jump_disable;
      addr_d        = addr_q;
      halted_d      = 1'b0;
      pend_valid_d  = pend_valid_q;
      pend_clint_d  = pend_clint_q;
      pend_addr_d   = pend_addr_q;
      flush_cnt_d   = flush_cnt_q;
      redirect      = 1'b0;
      redirect_addr = addr_q;

      unique case (state_q)
         st_run: begin
            if (pif.jtag_reset_i) begin
               redirect      = 1'b1;
               redirect_addr = RESET_ADDR;
            end else if (pif.jtag_halt_i) begin
               hold_d   = hold_wait;
               halted_d = 1'b1;
               state_d  = st_halt;
            end else if ((pif.clint_jump_flag_i || pif.ex_jump_flag_i) && pif.bus_hold_i) begin
               pend_valid_d = 1'b1;
               pend_clint_d = pif.clint_jump_flag_i;
               pend_addr_d  = pif.clint_jump_flag_i ? pif.clint_jump_addr_i : pif.ex_jump_addr_i;
               hold_d       = hold_wait;
               state_d      = st_pend;
            end else if (pif.clint_jump_flag_i) begin
               redirect      = 1'b1;
               redirect_addr = pif.clint_jump_addr_i;
            end else if (pif.ex_jump_flag_i) begin
               redirect      = 1'b1;
               redirect_addr = pif.ex_jump_addr_i;
            end else if (pif.ex_hold_i || pif.clint_hold_i || pif.bus_hold_i) begin
               hold_d = hold_wait;
            end
         end

         st_flush: begin
            if (pif.jtag_reset_i) begin
               redirect      = 1'b1;
               redirect_addr = RESET_ADDR;
            end else begin
               hold_d = hold_flush;
               if (pif.clint_jump_flag_i && !pend_valid_q) begin
                  pend_valid_d = 1'b1;
                  pend_clint_d = 1'b1;
                  pend_addr_d  = pif.clint_jump_addr_i;
               end
               flush_cnt_d = flush_cnt_q - 3'd1;
               if (flush_cnt_q == 3'd1) begin
                  state_d = pend_valid_d ? st_pend : st_run;
               end
            end
         end

         st_pend: begin
            if (pif.jtag_reset_i) begin
               redirect      = 1'b1;
               redirect_addr = RESET_ADDR;
            end else begin
               if (pif.clint_jump_flag_i && !pend_clint_q) begin
                  pend_clint_d = 1'b1;
                  pend_addr_d  = pif.clint_jump_addr_i;
               end
               if (pif.bus_hold_i) begin
                  hold_d = hold_wait;
               end else begin
                  redirect      = 1'b1;
                  redirect_addr = pend_addr_d;
               end
            end
         end

         st_halt: begin
            if (pif.jtag_reset_i) begin
               jump_d   = jump_enable;
               addr_d   = RESET_ADDR;
               hold_d   = hold_wait;
               halted_d = 1'b1;
            end else if (pif.jtag_halt_i) begin
               hold_d   = hold_wait;
               halted_d = 1'b1;
            end else begin
               state_d = st_run;
            end
         end

         default: state_d = st_run;
      endcase

      if (redirect) begin
         jump_d       = jump_enable;
         addr_d       = redirect_addr;
         hold_d       = hold_flush;
         pend_valid_d = 1'b0;
         pend_clint_d = 1'b0;
         flush_cnt_d  = FLUSH_EXTRA;
         state_d      = (FLUSH_EXTRA == 3'd0) ? st_run : st_flush;
      end
   end

   // State, pending slot and registered outputs.
   always_ff @(posedge clk or posedge rst) begin
      if (rst) begin
         state_q      <= st_run;
         hold_q       <= hold_no;
         jump_q       <= jump_disable;
         addr_q       <= '0;
         halted_q     <= 1'b0;
         pend_valid_q <= 1'b0;
         pend_clint_q <= 1'b0;
         pend_addr_q  <= '0;
         flush_cnt_q  <= '0;
      end else begin
         state_q      <= state_d;
         hold_q       <= hold_d;
         jump_q       <= jump_d;
         addr_q       <= addr_d;
         halted_q     <= halted_d;
         pend_valid_q <= pend_valid_d;
         pend_clint_q <= pend_clint_d;
         pend_addr_q  <= pend_addr_d;
         flush_cnt_q  <= flush_cnt_d;
      end
   end

   pip_ctrl_wdt #(
      .BUS_TIMEOUT(BUS_TIMEOUT)
   ) u_wdt (
      .clk          (clk),
      .rst          (rst),
      .bus_hold_i   (pif.bus_hold_i),
      .bus_timeout_o(pif.bus_timeout_o)
   );

   assign pif.hold_flag_o = hold_q;
   assign pif.jump_flag_o = jump_q;
   assign pif.jump_addr_o = addr_q;
   assign pif.halted_o    = halted_q;

endmodule

// File: tb/tb_pip_ctrl.sv
// Testbench for pip_ctrl: directed scenarios followed by random traffic, all
// checked cycle by cycle against a behavioural model of the controller rules.
module tb_pip_ctrl;

   localparam int          ADDR_W = 32;
   localparam int          FLUSH_N = 2;
   localparam logic [31:0] RST_ADDR = 32'h0000_8000;
   localparam int          TIMEOUT = 8;

   logic clk;
   logic rst;
   int   checks;
   int   errors;

   pip_ctrl_if #(.ADDR_W(ADDR_W)) pif ();

   pip_ctrl #(
      .ADDR_W      (ADDR_W),
      .FLUSH_CYCLES(FLUSH_N),
      .RESET_ADDR  (RST_ADDR),
      .BUS_TIMEOUT (TIMEOUT)
   ) dut (
      .clk(clk),
      .rst(rst),
      .pif(pif)
   );

   // Free-running clock, period 10.
   initial begin
      clk = 1'b0;
      forever #5 clk = ~clk;
   end

   // Reference model: a halted flag, a count of flush cycles still owed, a
   // one-entry pending slot and a running stall length.
   bit          m_halted;
   int          m_flush_left;
   bit          m_pend_valid;
   bit          m_pend_clint;
   logic [31:0] m_pend_addr;
   int          m_stall;
   logic [1:0]  e_hold;
   logic        e_jump;
   logic [31:0] e_addr;
   logic        e_halted;
   logic        e_to;

   task automatic modelReset();
      m_halted     = 0;
      m_flush_left = 0;
      m_pend_valid = 0;
      m_pend_clint = 0;
      m_pend_addr  = '0;
      m_stall      = 0;
      e_hold       = 2'b00;
      e_jump       = 1'b0;
      e_addr       = '0;
      e_halted     = 1'b0;
      e_to         = 1'b0;
   endtask

   task automatic modelRedirect(input logic [31:0] target);
      e_jump       = 1'b1;
      e_addr       = target;
      e_hold       = 2'b10;
      m_flush_left = FLUSH_N - 1;
      m_pend_valid = 0;
      m_pend_clint = 0;
   endtask

   task automatic modelStep(input logic ej, input logic [31:0] ea, input logic eh,
                            input logic cj, input logic [31:0] ca, input logic ch,
                            input logic bh, input logic jh, input logic jr);
      e_jump   = 1'b0;
      e_halted = 1'b0;
      e_hold   = 2'b00;
      if (m_halted) begin
         if (jr) begin
            e_jump = 1'b1; e_addr = RST_ADDR; e_hold = 2'b01; e_halted = 1'b1;
         end else if (jh) begin
            e_hold = 2'b01; e_halted = 1'b1;
         end else begin
            m_halted = 0;
         end
      end else if (m_flush_left > 0) begin
         if (jr) modelRedirect(RST_ADDR);
         else begin
            if (cj && !m_pend_valid) begin
               m_pend_valid = 1; m_pend_clint = 1; m_pend_addr = ca;
            end
            e_hold = 2'b10;
            m_flush_left--;
         end
      end else if (m_pend_valid) begin
         if (jr) modelRedirect(RST_ADDR);
         else begin
            if (cj && !m_pend_clint) begin
               m_pend_clint = 1; m_pend_addr = ca;
            end
            if (bh) e_hold = 2'b01;
            else modelRedirect(m_pend_addr);
         end
      end else begin
         if (jr) modelRedirect(RST_ADDR);
         else if (jh) begin
            e_hold = 2'b01; e_halted = 1'b1; m_halted = 1;
         end else if ((cj || ej) && bh) begin
            m_pend_valid = 1; m_pend_clint = cj; m_pend_addr = cj ? ca : ea;
            e_hold = 2'b01;
         end else if (cj) modelRedirect(ca);
         else if (ej) modelRedirect(ea);
         else if (eh || ch || bh) e_hold = 2'b01;
      end
      e_to = 1'b0;
      if (!bh) m_stall = 0;
      else if (m_stall < TIMEOUT) begin
         m_stall++;
         e_to = (m_stall == TIMEOUT);
      end
   endtask

   task automatic check1(input string tag, input logic [31:0] obs, input logic [31:0] exp);
      checks++;
      assert (obs === exp) else begin
         errors++;
         $error("[TB] FAIL %s observed %h expected %h", tag, obs, exp);
      end
   endtask

   task automatic checkOutput(input string tag);
      check1({tag, ".hold"},    32'(pif.hold_flag_o),   32'(e_hold));
      check1({tag, ".jump"},    32'(pif.jump_flag_o),   32'(e_jump));
      check1({tag, ".addr"},    pif.jump_addr_o,        e_addr);
      check1({tag, ".halted"},  32'(pif.halted_o),      32'(e_halted));
      check1({tag, ".timeout"}, 32'(pif.bus_timeout_o), 32'(e_to));
   endtask

   // Drive one cycle of inputs just after an edge, advance the model, check after the next edge.
   task automatic applyStimulus(input string tag,
                                input logic ej, input logic [31:0] ea, input logic eh,
                                input logic cj, input logic [31:0] ca, input logic ch,
                                input logic bh, input logic jh, input logic jr);
      pif.ex_jump_flag_i    = ej;
      pif.ex_jump_addr_i    = ea;
      pif.ex_hold_i         = eh;
      pif.clint_jump_flag_i = cj;
      pif.clint_jump_addr_i = ca;
      pif.clint_hold_i      = ch;
      pif.bus_hold_i        = bh;
      pif.jtag_halt_i       = jh;
      pif.jtag_reset_i      = jr;
      modelStep(ej, ea, eh, cj, ca, ch, bh, jh, jr);
      @(posedge clk);
      #1;
      checkOutput(tag);
   endtask

   task automatic idle(input string tag);
      applyStimulus(tag, 0, '0, 0, 0, '0, 0, 0, 0, 0);
   endtask

   task automatic checkResetValues(input string tag);
      check1({tag, ".hold"},    32'(pif.hold_flag_o),   32'h0);
      check1({tag, ".jump"},    32'(pif.jump_flag_o),   32'h0);
      check1({tag, ".addr"},    pif.jump_addr_o,        32'h0);
      check1({tag, ".halted"},  32'(pif.halted_o),      32'h0);
      check1({tag, ".timeout"}, 32'(pif.bus_timeout_o), 32'h0);
   endtask

   int          pulses;
   logic        r_bh;
   logic        r_jh;
   logic [31:0] r_ea;
   logic [31:0] r_ca;

   initial begin
      checks = 0;
      errors = 0;
      rst    = 1'b1;
      pif.ex_jump_flag_i    = 0;
      pif.ex_jump_addr_i    = '0;
      pif.ex_hold_i         = 0;
      pif.clint_jump_flag_i = 0;
      pif.clint_jump_addr_i = '0;
      pif.clint_hold_i      = 0;
      pif.bus_hold_i        = 0;
      pif.jtag_halt_i       = 0;
      pif.jtag_reset_i      = 0;
      modelReset();
      #2;
      checkResetValues("reset");
      @(posedge clk);
      #1;
      rst = 1'b0;

      // Single execute redirect with a two-cycle flush.
      applyStimulus("ex_jump", 1, 32'h0200_0000, 0, 0, '0, 0, 0, 0, 0);
      check1("ex_jump.pulse", 32'(pif.jump_flag_o), 32'h1);
      check1("ex_jump.target", pif.jump_addr_o, 32'h0200_0000);
      idle("ex_flush");
      check1("ex_flush.hold", 32'(pif.hold_flag_o), 32'h2);
      idle("ex_done");
      check1("ex_done.hold", 32'(pif.hold_flag_o), 32'h0);

      // CLINT wins over execute in the same cycle.
      applyStimulus("both_jump", 1, 32'h0000_0200, 0, 1, 32'h0000_0100, 0, 0, 0, 0);
      check1("both_jump.target", pif.jump_addr_o, 32'h0000_0100);
      idle("both_flush");
      idle("both_done");

      // Redirects deferred across a five-cycle bus stall; CLINT overrides the stored ex target.
      applyStimulus("pend1", 1, 32'h40, 0, 0, '0, 0, 1, 0, 0);
      applyStimulus("pend2", 0, '0, 0, 0, '0, 0, 1, 0, 0);
      applyStimulus("pend3", 0, '0, 0, 1, 32'h80, 0, 1, 0, 0);
      applyStimulus("pend4", 0, '0, 0, 0, '0, 0, 1, 0, 0);
      applyStimulus("pend5", 0, '0, 0, 0, '0, 0, 1, 0, 0);
      check1("pend5.hold", 32'(pif.hold_flag_o), 32'h1);
      idle("pend_issue");
      check1("pend_issue.target", pif.jump_addr_o, 32'h80);
      idle("pend_flush");
      idle("pend_done");

      // Four-cycle debug halt with an ignored execute jump inside it.
      applyStimulus("halt1", 0, '0, 0, 0, '0, 0, 0, 1, 0);
      applyStimulus("halt2", 1, 32'h1234, 0, 0, '0, 0, 0, 1, 0);
      applyStimulus("halt3", 0, '0, 0, 0, '0, 0, 0, 1, 0);
      applyStimulus("halt4", 0, '0, 0, 0, '0, 0, 0, 1, 0);
      check1("halt4.halted", 32'(pif.halted_o), 32'h1);
      idle("halt_exit");
      check1("halt_exit.hold", 32'(pif.hold_flag_o), 32'h0);

      // Watchdog: one pulse in a 20-cycle stall, another after re-arming for 8 cycles.
      pulses = 0;
      for (int i = 0; i < 20; i++) begin
         applyStimulus("wdt_long", 0, '0, 0, 0, '0, 0, 1, 0, 0);
         if (pif.bus_timeout_o === 1'b1) pulses++;
      end
      check1("wdt_long.pulses", 32'(pulses), 32'd1);
      idle("wdt_drop");
      pulses = 0;
      for (int i = 0; i < TIMEOUT; i++) begin
         applyStimulus("wdt_again", 0, '0, 0, 0, '0, 0, 1, 0, 0);
         if (pif.bus_timeout_o === 1'b1) pulses++;
      end
      check1("wdt_again.pulses", 32'(pulses), 32'd1);
      idle("wdt_clear");

      // Random traffic with sticky bus stall and halt levels.
      r_bh = 0;
      r_jh = 0;
      for (int i = 0; i < 600; i++) begin
         if ($urandom_range(0, 3) == 0)  r_bh = ~r_bh;
         if ($urandom_range(0, 15) == 0) r_jh = ~r_jh;
         r_ea = {$urandom_range(0, 32'hFFFF), 2'b00} << 2;
         r_ca = {$urandom_range(0, 32'hFFFF), 2'b00} << 4;
         applyStimulus("random",
                       1'($urandom_range(0, 3) == 0), r_ea, 1'($urandom_range(0, 7) == 0),
                       1'($urandom_range(0, 7) == 0), r_ca, 1'($urandom_range(0, 7) == 0),
                       r_bh, r_jh, 1'($urandom_range(0, 31) == 0));
      end
      idle("random_end1");
      idle("random_end2");
      idle("random_end3");

      // Asynchronous reset in the middle of a deferred redirect.
      applyStimulus("rst_pend", 1, 32'h0000_0444, 0, 0, '0, 0, 1, 0, 0);
      applyStimulus("rst_pend_wait", 0, '0, 0, 0, '0, 0, 1, 0, 0);
      #3;
      rst = 1'b1;
      #1;
      checkResetValues("async_rst");
      @(posedge clk);
      #1;
      pif.bus_hold_i     = 0;
      pif.ex_jump_flag_i = 0;
      rst = 1'b0;
      modelReset();
      idle("post_rst1");
      check1("post_rst1.nojump", 32'(pif.jump_flag_o), 32'h0);
      idle("post_rst2");
      idle("post_rst3");

      $display("CHECKS %0d ERRORS %0d", checks, errors);
      $finish;
   end

endmodule
